// File: rtl/sound_latch_bridge.sv
// sound_latch_bridge
// Command/reply mailbox between the 68K and the Z80 sound CPU.
// The 68K writes a command byte, the Z80 is interrupted through NMI, reads the
// byte from F800h and may write a reply byte back that the 68K can read at
// any time. A new command that lands before the Z80 read the previous one
// forces NMI high for NMI_GAP cycles so the Z80 sees a fresh falling edge.
//
// Strobe semantics: there is no valid/ready handshake. Every strobe is treated
// as a level that produces exactly one event on its first cycle high. The
// event is detected against a registered copy of the strobe. Holding a strobe
// high has no further effect until it has dropped and risen again.

module sound_latch_bridge #(
  parameter int NMI_GAP = 4,     // cycles of forced-high NMI on re-arm (>=1)
  parameter bit CMD_HI  = 1'b1   // 1: command from m68k_din[15:8], 0: [7:0]
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m68k_latch_cs,
  input  logic [15:0] m68k_din,
  input  logic        z80_latch_read_cs,
  input  logic        z80_latch_cs,
  input  logic        z80_rd_n,
  input  logic        z80_wr_n,
  input  logic [7:0]  z80_din,
  output logic [7:0]  z80_latch_dout,
  output logic [15:0] m68k_reply_dout,
  output logic        z80_nmi_n,
  output logic        cmd_pending,
  output logic        cmd_overrun,
  output logic [1:0]  dbg_state
);

  localparam int              CW       = $clog2(NMI_GAP) + 1;
  localparam logic [CW-1:0]   GAP_LOAD = CW'(NMI_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_gap_cnt;
  logic            r_nmi_n;

  logic            r_m68k_cs_q;
  logic            r_z80_rd_q;
  logic            r_z80_wr_q;

  logic [7:0]      r_cmd;
  logic [7:0]      r_reply;
  logic            r_cmd_pending;
  logic            r_cmd_overrun;

  logic            w_z80_rd_strobe;
  logic            w_z80_wr_strobe;
  logic            w_wr68;
  logic            w_rdz;
  logic            w_wrz;
  logic [7:0]      w_cmd_byte;
  logic            w_unused;

  // The reply latch is always presented, so the 68K read strobe carries no
  // information here; the unselected half of the 68K data bus is ignored.
  assign w_unused = &{1'b0, z80_latch_read_cs, m68k_din};

  assign w_z80_rd_strobe = z80_latch_cs & ~z80_rd_n;
  assign w_z80_wr_strobe = z80_latch_cs & ~z80_wr_n;

  assign w_wr68 = m68k_latch_cs   & ~r_m68k_cs_q;
  assign w_rdz  = w_z80_rd_strobe & ~r_z80_rd_q;
  assign w_wrz  = w_z80_wr_strobe & ~r_z80_wr_q;

  assign w_cmd_byte = CMD_HI ? m68k_din[15:8] : m68k_din[7:0];

  // Registered copies of the strobes used for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m68k_cs_q <= 1'b0;
      r_z80_rd_q  <= 1'b0;
      r_z80_wr_q  <= 1'b0;
    end else begin
      r_m68k_cs_q <= m68k_latch_cs;
      r_z80_rd_q  <= w_z80_rd_strobe;
      r_z80_wr_q  <= w_z80_wr_strobe;
    end
  end

  // Command latch, pending flag and sticky overrun; a 68K write beats a
  // same-cycle Z80 read, and that collision is not an overrun
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd         <= 8'h00;
      r_cmd_pending <= 1'b0;
      r_cmd_overrun <= 1'b0;
    end else begin
      if (w_wr68) begin
        r_cmd         <= w_cmd_byte;
        r_cmd_pending <= 1'b1;
        if (r_cmd_pending && !w_rdz) begin
          r_cmd_overrun <= 1'b1;
        end
      end else if (w_rdz) begin
        r_cmd_pending <= 1'b0;
      end
    end
  end

  // Reply latch written by the Z80
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reply <= 8'h00;
    end else if (w_wrz) begin
      r_reply <= z80_din;
    end
  end

  // NMI sequencer; nmi_n is registered alongside the state so it is low
  // exactly while the state is ASSERT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_gap_cnt <= '0;
      r_nmi_n   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr68) begin
            r_state <= S_ASSERT;
            r_nmi_n <= 1'b0;
          end
        end
        S_ASSERT: begin
          if (w_wr68) begin
            // Back-to-back command: release NMI to create a new edge later
            r_state   <= S_GAP;
            r_gap_cnt <= GAP_LOAD;
            r_nmi_n   <= 1'b1;
          end else if (w_rdz) begin
            r_state <= S_IDLE;
            r_nmi_n <= 1'b1;
          end
        end
        S_GAP: begin
          // Writes during the gap only touch the latch; the count runs on
          if (r_gap_cnt == '0) begin
            if (r_cmd_pending) begin
              r_state <= S_ASSERT;
              r_nmi_n <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_nmi_n <= 1'b1;
        end
      endcase
    end
  end

  assign z80_latch_dout  = r_cmd;
  assign m68k_reply_dout = {8'h00, r_reply};
  assign z80_nmi_n       = r_nmi_n;
  assign cmd_pending     = r_cmd_pending;
  assign cmd_overrun     = r_cmd_overrun;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_sound_latch_bridge.sv
// Self-checking bench for sound_latch_bridge: directed scenarios followed by
// randomized traffic, all compared against an event-level mailbox model.

module tb_sound_latch_bridge;

  localparam int NMI_GAP = 4;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic        m68k_latch_cs;
  logic [15:0] m68k_din;
  logic        z80_latch_read_cs;
  logic        z80_latch_cs;
  logic        z80_rd_n;
  logic        z80_wr_n;
  logic [7:0]  z80_din;
  logic [7:0]  z80_latch_dout;
  logic [15:0] m68k_reply_dout;
  logic        z80_nmi_n;
  logic        cmd_pending;
  logic        cmd_overrun;
  logic [1:0]  dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sound_latch_bridge #(.NMI_GAP(NMI_GAP), .CMD_HI(1'b1)) dut (
    .clk               (clk),
    .reset             (reset),
    .m68k_latch_cs     (m68k_latch_cs),
    .m68k_din          (m68k_din),
    .z80_latch_read_cs (z80_latch_read_cs),
    .z80_latch_cs      (z80_latch_cs),
    .z80_rd_n          (z80_rd_n),
    .z80_wr_n          (z80_wr_n),
    .z80_din           (z80_din),
    .z80_latch_dout    (z80_latch_dout),
    .m68k_reply_dout   (m68k_reply_dout),
    .z80_nmi_n         (z80_nmi_n),
    .cmd_pending       (cmd_pending),
    .cmd_overrun       (cmd_overrun),
    .dbg_state         (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model speaks in mailbox terms: a command byte, whether it is unread,
  // whether one was lost, and how many forced-high NMI cycles remain.
  logic [7:0] m_cmd, m_reply;
  bit         m_pending, m_overrun;
  bit         m_nmi_low;
  int         m_gap_left;               // forced-high cycles still to run
  bit         p_cs, p_rd, p_wr;         // strobe levels seen last cycle

  task automatic model_reset();
    m_cmd = 8'h00; m_reply = 8'h00;
    m_pending = 0; m_overrun = 0;
    m_nmi_low = 0; m_gap_left = 0;
    p_cs = 0; p_rd = 0; p_wr = 0;
  endtask

  task automatic model_clock();
    bit rd_lvl, wr_lvl, wr68, rdz, wrz, was_pending;
    rd_lvl = z80_latch_cs && !z80_rd_n;
    wr_lvl = z80_latch_cs && !z80_wr_n;
    wr68 = m68k_latch_cs && !p_cs;
    rdz  = rd_lvl && !p_rd;
    wrz  = wr_lvl && !p_wr;
    p_cs = m68k_latch_cs; p_rd = rd_lvl; p_wr = wr_lvl;
    was_pending = m_pending;

    if (wr68) begin
      if (m_pending && !rdz) m_overrun = 1;
      m_cmd = m68k_din[15:8];
      m_pending = 1;
    end else if (rdz) begin
      m_pending = 0;
    end
    if (wrz) m_reply = z80_din;

    if (m_gap_left > 0) begin
      if (m_gap_left == 1) m_nmi_low = was_pending;
      m_gap_left--;
    end else if (m_nmi_low) begin
      if (wr68) begin
        m_nmi_low = 0;
        m_gap_left = NMI_GAP;
      end else if (rdz) begin
        m_nmi_low = 0;
      end
    end else if (wr68) begin
      m_nmi_low = 1;
    end
  endtask

  task automatic compare_model(input string tag);
    check_val({tag, ".cmd"},     {8'h00, z80_latch_dout}, {8'h00, m_cmd});
    check_val({tag, ".reply"},   m68k_reply_dout,         {8'h00, m_reply});
    check_val({tag, ".nmi_n"},   {15'd0, z80_nmi_n},      {15'd0, !m_nmi_low});
    check_val({tag, ".pending"}, {15'd0, cmd_pending},    {15'd0, m_pending});
    check_val({tag, ".overrun"}, {15'd0, cmd_overrun},    {15'd0, m_overrun});
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input bit cs68, input logic [15:0] d68, input bit zcs,
                       input bit rdn, input bit wrn, input logic [7:0] dz);
    m68k_latch_cs = cs68; m68k_din = d68;
    z80_latch_cs = zcs; z80_rd_n = rdn; z80_wr_n = wrn; z80_din = dz;
    z80_latch_read_cs = 1'($urandom_range(0, 1));
  endtask

  // One clock: inputs already driven, advance, update model, compare.
  task automatic step(input string tag);
    @(posedge clk);
    model_clock();
    #1;
    compare_model(tag);
  endtask

  task automatic idle(input string tag);
    drive(0, 16'h0000, 0, 1, 1, 8'h00);
    step(tag);
  endtask

  task automatic do_reset();
    drive(0, 16'h0000, 0, 1, 1, 8'h00);
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    compare_model("reset");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    drive(0, 16'h0000, 0, 1, 1, 8'h00);
    model_reset();
    #2;
    do_reset();
    check_val("rst_nmi_n", {15'd0, z80_nmi_n}, 16'd1);
    check_val("rst_state", {14'd0, dbg_state}, 16'd0);

    // 1: single command
    drive(1, 16'h3A00, 0, 1, 1, 8'h00); step("t1_wr");
    check_val("t1_dout",    {8'h00, z80_latch_dout}, 16'h003A);
    check_val("t1_pending", {15'd0, cmd_pending},    16'd1);
    check_val("t1_nmi_n",   {15'd0, z80_nmi_n},      16'd0);
    idle("t1_idle");

    // 2: Z80 read, then hold the read strobe
    drive(0, 16'h0000, 1, 0, 1, 8'h00); step("t2_rd");
    check_val("t2_pending", {15'd0, cmd_pending}, 16'd0);
    check_val("t2_nmi_n",   {15'd0, z80_nmi_n},   16'd1);
    for (int i = 0; i < 10; i++) step("t2_hold");
    check_val("t2_hold_nmi_n", {15'd0, z80_nmi_n}, 16'd1);
    idle("t2_idle");

    // 3: back-to-back commands re-arm NMI after a 4-cycle gap
    drive(1, 16'h1100, 0, 1, 1, 8'h00); step("t3_wr11");
    idle("t3_idle");
    drive(1, 16'h2200, 0, 1, 1, 8'h00); step("t3_wr22");
    check_val("t3_gap0", {15'd0, z80_nmi_n}, 16'd1);
    for (int i = 1; i < NMI_GAP; i++) begin
      idle("t3_gap");
      check_val("t3_gap_hi", {15'd0, z80_nmi_n}, 16'd1);
    end
    idle("t3_rearm");
    check_val("t3_nmi_low", {15'd0, z80_nmi_n},      16'd0);
    check_val("t3_dout",    {8'h00, z80_latch_dout}, 16'h0022);
    check_val("t3_overrun", {15'd0, cmd_overrun},    16'd1);

    // 4: simultaneous Z80 read and 68K write
    do_reset();
    drive(1, 16'h3300, 0, 1, 1, 8'h00); step("t4_wr33");
    idle("t4_idle");
    drive(1, 16'h5500, 1, 0, 1, 8'h00); step("t4_coll");
    check_val("t4_pending", {15'd0, cmd_pending},    16'd1);
    check_val("t4_dout",    {8'h00, z80_latch_dout}, 16'h0055);
    check_val("t4_overrun", {15'd0, cmd_overrun},    16'd0);
    check_val("t4_gap",     {15'd0, z80_nmi_n},      16'd1);
    for (int i = 1; i < NMI_GAP; i++) idle("t4_gap");
    idle("t4_rearm");
    check_val("t4_nmi_low", {15'd0, z80_nmi_n}, 16'd0);

    // 5: Z80 reply write
    drive(0, 16'h0000, 1, 1, 0, 8'h9C); step("t5_wrz");
    check_val("t5_reply",   m68k_reply_dout,         16'h009C);
    check_val("t5_pending", {15'd0, cmd_pending},    16'd1);
    check_val("t5_dout",    {8'h00, z80_latch_dout}, 16'h0055);
    idle("t5_idle");

    // 6: asynchronous reset in the middle of a gap
    drive(1, 16'h7700, 0, 1, 1, 8'h00); step("t6_wr77");
    idle("t6_gap");
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_val("t6_nmi_n",   {15'd0, z80_nmi_n},      16'd1);
    check_val("t6_dout",    {8'h00, z80_latch_dout}, 16'h0000);
    check_val("t6_reply",   m68k_reply_dout,         16'h0000);
    check_val("t6_pending", {15'd0, cmd_pending},    16'd0);
    check_val("t6_overrun", {15'd0, cmd_overrun},    16'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    idle("t6_after");
    check_val("t6_state", {14'd0, dbg_state}, 16'd0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 3) == 0), 16'($urandom),
            ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 8'($urandom));
      step("rand");
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
